// File: rtl/arcanoid_pkg.sv
// Shared constants for the brick layer: grid geometry defaults, mortar widths,
// per-row brick colours and the hit FSM state encoding.
package arcanoid_pkg;

  localparam int GRID_ROWS_DEF    = 8;
  localparam int GRID_COLS_DEF    = 16;
  localparam int GRID_Y0_DEF      = 64;
  localparam int BRICK_W_LOG2_DEF = 6;
  localparam int BRICK_H_LOG2_DEF = 5;

  // Mortar occupies the last MORTAR_W columns / MORTAR_H lines of each brick cell
  localparam int MORTAR_W = 2;
  localparam int MORTAR_H = 2;

  localparam logic [0:7][11:0] ROW_COLOUR = {
    12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
    12'h0FF, 12'h00F, 12'h80F, 12'hF0F
  };

  typedef enum logic [1:0] {
    HIT_IDLE    = 2'd0,
    HIT_LOOKUP  = 2'd1,
    HIT_RESPOND = 2'd2
  } hit_state_e;

  function automatic logic [11:0] row_colour(input logic [2:0] row);
    return ROW_COLOUR[row];
  endfunction

endpackage

// File: rtl/brick_map.sv
// Live-brick bitmap with live counter; one render read port, one hit read port,
// a single clear port and a restore that overrides any clear on the same edge.
module brick_map
  import arcanoid_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS_DEF,
  parameter int COLS  = GRID_COLS_DEF,
  parameter int IDX_W = $clog2(ROWS * COLS),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restore,
  input  logic             clear_en,
  input  logic [IDX_W-1:0] clear_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_live,
  input  logic [IDX_W-1:0] hit_idx,
  output logic             hit_live,
  output logic [CNT_W-1:0] count,
  output logic             all_cleared
);

  localparam int N = ROWS * COLS;

  logic [N-1:0]     map_q, map_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             all_cleared_q, all_cleared_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign map_d[gi] = restore ? 1'b1 :
                         (clear_en && (clear_idx == IDX_W'(gi))) ? 1'b0 : map_q[gi];
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (restore) begin
      count_d = CNT_W'(N);
    end else if (clear_en && map_q[clear_idx] && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
    all_cleared_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_q         <= '1;
      count_q       <= CNT_W'(N);
      all_cleared_q <= (N == 0);
    end else begin
      map_q         <= map_d;
      count_q       <= count_d;
      all_cleared_q <= all_cleared_d;
    end
  end

  assign rd_live     = map_q[rd_idx];
  assign hit_live    = map_q[hit_idx];
  assign count       = count_q;
  assign all_cleared = all_cleared_q;

endmodule

// File: rtl/draw_bricks.sv
// Composites the brick wall over the background video with one cycle of latency
// and answers ball-probe hit requests through a three-state lookup FSM.
module draw_bricks
  import arcanoid_pkg::*;
#(
  parameter int BRICK_ROWS   = GRID_ROWS_DEF,
  parameter int BRICK_COLS   = GRID_COLS_DEF,
  parameter int GRID_Y0      = GRID_Y0_DEF,
  parameter int BRICK_W_LOG2 = BRICK_W_LOG2_DEF,
  parameter int BRICK_H_LOG2 = BRICK_H_LOG2_DEF
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  input  logic        hit_valid,
  input  logic [11:0] hit_x,
  input  logic [11:0] hit_y,
  output logic        hit_ack,
  output logic        hit_brick,
  input  logic        level_restore,
  output logic [7:0]  bricks_left,
  output logic        all_cleared
);

  localparam int N     = BRICK_ROWS * BRICK_COLS;
  localparam int IDX_W = $clog2(N);
  localparam logic [BRICK_W_LOG2-1:0] H_MORTAR = BRICK_W_LOG2'((1 << BRICK_W_LOG2) - MORTAR_W);
  localparam logic [BRICK_H_LOG2-1:0] V_MORTAR = BRICK_H_LOG2'((1 << BRICK_H_LOG2) - MORTAR_H);

  // Render-side grid decode (11-bit video counters)
  logic [10:0]      r_rel, r_row, r_col;
  logic             r_in_grid, r_mortar, r_live;
  logic [IDX_W-1:0] r_idx;

  always_comb begin
    r_rel     = vcount_in - 11'(GRID_Y0);
    r_row     = r_rel >> BRICK_H_LOG2;
    r_col     = hcount_in >> BRICK_W_LOG2;
    r_in_grid = (vcount_in >= 11'(GRID_Y0)) && (r_row < 11'(BRICK_ROWS)) &&
                (r_col < 11'(BRICK_COLS));
    r_mortar  = (hcount_in[BRICK_W_LOG2-1:0] >= H_MORTAR) ||
                (r_rel[BRICK_H_LOG2-1:0] >= V_MORTAR);
    r_idx     = IDX_W'(r_row * 11'(BRICK_COLS) + r_col);
  end

  // Hit-side grid decode on the latched probe (12-bit arithmetic)
  hit_state_e       state_q, state_d;
  logic [11:0]      hx_q, hx_d, hy_q, hy_d;
  logic             hit_ack_q, hit_ack_d, hit_brick_q, hit_brick_d;
  logic [11:0]      h_rel, h_row, h_col;
  logic             h_in_grid, h_mortar, h_live, strike;
  logic [IDX_W-1:0] h_idx;

  always_comb begin
    h_rel     = hy_q - 12'(GRID_Y0);
    h_row     = h_rel >> BRICK_H_LOG2;
    h_col     = hx_q >> BRICK_W_LOG2;
    h_in_grid = (hy_q >= 12'(GRID_Y0)) && (h_row < 12'(BRICK_ROWS)) &&
                (h_col < 12'(BRICK_COLS));
    h_mortar  = (hx_q[BRICK_W_LOG2-1:0] >= H_MORTAR) ||
                (h_rel[BRICK_H_LOG2-1:0] >= V_MORTAR);
    h_idx     = IDX_W'(h_row * 12'(BRICK_COLS) + h_col);
    strike    = (state_q == HIT_LOOKUP) && h_in_grid && !h_mortar && h_live;
  end

  always_comb begin
    state_d     = state_q;
    hx_d        = hx_q;
    hy_d        = hy_q;
    hit_ack_d   = 1'b0;
    hit_brick_d = 1'b0;
    case (state_q)
      HIT_IDLE: begin
        if (hit_valid) begin
          state_d = HIT_LOOKUP;
          hx_d    = hit_x;
          hy_d    = hit_y;
        end
      end
      HIT_LOOKUP: begin
        state_d     = HIT_RESPOND;
        hit_ack_d   = 1'b1;
        hit_brick_d = strike;
      end
      HIT_RESPOND: state_d = HIT_IDLE;
      default:     state_d = HIT_IDLE;
    endcase
    if (level_restore) begin
      state_d     = HIT_IDLE;
      hit_ack_d   = 1'b0;
      hit_brick_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= HIT_IDLE;
      hx_q        <= '0;
      hy_q        <= '0;
      hit_ack_q   <= 1'b0;
      hit_brick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      hit_ack_q   <= hit_ack_d;
      hit_brick_q <= hit_brick_d;
    end
  end

  brick_map #(
    .ROWS  (BRICK_ROWS),
    .COLS  (BRICK_COLS),
    .IDX_W (IDX_W),
    .CNT_W (8)
  ) u_map (
    .clk         (pclk),
    .reset       (reset),
    .restore     (level_restore),
    .clear_en    (strike),
    .clear_idx   (h_idx),
    .rd_idx      (r_idx),
    .rd_live     (r_live),
    .hit_idx     (h_idx),
    .hit_live    (h_live),
    .count       (bricks_left),
    .all_cleared (all_cleared)
  );

  // Video path: one register stage on every output
  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    hcount_d = hcount_in;
    vcount_d = vcount_in;
    hsync_d  = hsync_in;
    vsync_d  = vsync_in;
    hblnk_d  = hblnk_in;
    vblnk_d  = vblnk_in;
    if (hblnk_in || vblnk_in) begin
      rgb_d = 12'h000;
    end else if (r_in_grid && !r_mortar && r_live) begin
      rgb_d = row_colour(r_row[2:0]);
    end else begin
      rgb_d = rgb_in;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      rgb_q    <= rgb_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;
  assign hit_ack    = hit_ack_q;
  assign hit_brick  = hit_brick_q;

endmodule

// File: tb/tb_draw_bricks.sv
// Directed bench for draw_bricks: rendering, hit handling, clear-all, restore and reset.
module tb_draw_bricks;

  logic        pclk = 1'b0;
  logic        reset;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        hit_valid;
  logic [11:0] hit_x, hit_y;
  logic        hit_ack, hit_brick, level_restore, all_cleared;
  logic [7:0]  bricks_left;

  int errors = 0;
  int checks = 0;

  always #8 pclk = ~pclk;

  draw_bricks dut (
    .pclk          (pclk),
    .reset         (reset),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .hblnk_in      (hblnk_in),
    .vblnk_in      (vblnk_in),
    .rgb_in        (rgb_in),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .hblnk_out     (hblnk_out),
    .vblnk_out     (vblnk_out),
    .rgb_out       (rgb_out),
    .hit_valid     (hit_valid),
    .hit_x         (hit_x),
    .hit_y         (hit_y),
    .hit_ack       (hit_ack),
    .hit_brick     (hit_brick),
    .level_restore (level_restore),
    .bricks_left   (bricks_left),
    .all_cleared   (all_cleared)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v);
    hcount_in = h;
    vcount_in = v;
    step(1);
  endtask

  // Request in cycle 0, ack expected in cycle 2 only
  task automatic probe(input logic [11:0] x, input logic [11:0] y,
                       input logic exp, input string tag);
    hit_valid = 1'b1;
    hit_x     = x;
    hit_y     = y;
    step(1);
    hit_valid = 1'b0;
    chk({tag, "_ack_early"}, 32'(hit_ack), 32'd0);
    step(1);
    chk({tag, "_ack"}, 32'(hit_ack), 32'd1);
    chk({tag, "_brick"}, 32'(hit_brick), 32'(exp));
    step(1);
    chk({tag, "_ack_drop"}, 32'(hit_ack), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    hcount_in = 11'd55; vcount_in = 11'd77;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h123;
    hit_valid = 1'b0; hit_x = '0; hit_y = '0; level_restore = 1'b0;
    step(2);
    chk("rst_rgb", 32'(rgb_out), 32'h000);
    chk("rst_hcount", 32'(hcount_out), 32'd0);
    chk("rst_hsync", 32'(hsync_out), 32'd0);
    chk("rst_ack", 32'(hit_ack), 32'd0);
    chk("rst_brick", 32'(hit_brick), 32'd0);
    chk("rst_left", 32'(bricks_left), 32'd128);
    chk("rst_cleared", 32'(all_cleared), 32'd0);
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;

    pix(11'd100, 11'd64);
    chk("row0_rgb", 32'(rgb_out), 32'hF00);
    chk("row0_hcount", 32'(hcount_out), 32'd100);
    chk("row0_vcount", 32'(vcount_out), 32'd64);
    chk("row0_left", 32'(bricks_left), 32'd128);
    pix(11'd5, 11'd291);
    chk("row7_rgb", 32'(rgb_out), 32'hF0F);
    pix(11'd190, 11'd80);
    chk("mortar_h_rgb", 32'(rgb_out), 32'h123);
    pix(11'd100, 11'd40);
    chk("above_grid_rgb", 32'(rgb_out), 32'h123);

    probe(12'd100, 12'd70, 1'b1, "hit_first");
    chk("hit_first_left", 32'(bricks_left), 32'd127);
    chk("hit_first_cleared", 32'(all_cleared), 32'd0);
    pix(11'd100, 11'd64);
    chk("dead_rgb", 32'(rgb_out), 32'h123);

    probe(12'd100, 12'd70, 1'b0, "hit_dead");
    chk("hit_dead_left", 32'(bricks_left), 32'd127);
    probe(12'd63, 12'd70, 1'b0, "hit_mortar_x");
    probe(12'd300, 12'd94, 1'b0, "hit_mortar_y");
    probe(12'd100, 12'd10, 1'b0, "hit_above");
    probe(12'd100, 12'd320, 1'b0, "hit_below");
    probe(12'd1030, 12'd70, 1'b0, "hit_right");
    chk("misses_left", 32'(bricks_left), 32'd127);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        probe(12'(c * 64 + 10), 12'(64 + r * 32 + 5), !((r == 0) && (c == 1)), "clr");
      end
    end
    chk("clr_left", 32'(bricks_left), 32'd0);
    chk("clr_cleared", 32'(all_cleared), 32'd1);
    probe(12'd100, 12'd70, 1'b0, "hit_empty");
    chk("hit_empty_left", 32'(bricks_left), 32'd0);

    level_restore = 1'b1;
    step(1);
    level_restore = 1'b0;
    chk("restore_left", 32'(bricks_left), 32'd128);
    chk("restore_cleared", 32'(all_cleared), 32'd0);

    hit_valid = 1'b1; hit_x = 12'd100; hit_y = 12'd70;
    step(1);
    hit_valid = 1'b0; level_restore = 1'b1;
    step(1);
    level_restore = 1'b0;
    chk("race_ack", 32'(hit_ack), 32'd0);
    chk("race_left", 32'(bricks_left), 32'd128);
    step(1);
    chk("race_ack_late", 32'(hit_ack), 32'd0);
    pix(11'd100, 11'd64);
    chk("race_rgb", 32'(rgb_out), 32'hF00);

    hit_valid = 1'b1; hit_x = 12'd0; hit_y = 12'd64;
    step(1);
    hit_x = 12'd300; hit_y = 12'd100;
    step(1);
    hit_valid = 1'b0;
    chk("busy_ack", 32'(hit_ack), 32'd1);
    chk("busy_brick", 32'(hit_brick), 32'd1);
    step(1);
    chk("busy_left", 32'(bricks_left), 32'd127);
    chk("busy_ack_drop", 32'(hit_ack), 32'd0);
    probe(12'd300, 12'd100, 1'b1, "ignored_live");
    chk("ignored_left", 32'(bricks_left), 32'd126);

    hsync_in = 1'b1; hblnk_in = 1'b1;
    pix(11'd100, 11'd64);
    chk("hblnk_rgb", 32'(rgb_out), 32'h000);
    chk("hblnk_hsync", 32'(hsync_out), 32'd1);
    chk("hblnk_vsync", 32'(vsync_out), 32'd0);
    chk("hblnk_flag", 32'(hblnk_out), 32'd1);
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b1; vblnk_in = 1'b1;
    pix(11'd100, 11'd64);
    chk("vblnk_rgb", 32'(rgb_out), 32'h000);
    chk("vblnk_vsync", 32'(vsync_out), 32'd1);
    chk("vblnk_hsync", 32'(hsync_out), 32'd0);
    chk("vblnk_flag", 32'(vblnk_out), 32'd1);
    vsync_in = 1'b0; vblnk_in = 1'b0;
    pix(11'd100, 11'd64);
    chk("unblank_rgb", 32'(rgb_out), 32'hF00);

    hit_valid = 1'b1; hit_x = 12'd100; hit_y = 12'd64;
    step(1);
    hit_valid = 1'b0; reset = 1'b1;
    step(1);
    chk("abort_ack", 32'(hit_ack), 32'd0);
    chk("abort_left", 32'(bricks_left), 32'd128);
    reset = 1'b0;
    step(1);
    chk("abort_ack_late", 32'(hit_ack), 32'd0);
    probe(12'd100, 12'd64, 1'b1, "post_abort");
    chk("post_abort_left", 32'(bricks_left), 32'd127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
